// File: rtl/mpu6050_gyro_assembler_if.sv
// Byte-stream and sample handshake bundle for the MPU6050 gyro assembler.
// master = byte source and sample consumer, slave = assembler.
interface mpu6050_gyro_assembler_if #(
   parameter int COUNT_WIDTH = 16
);
   logic [7:0]             byte_data;
   logic                   byte_valid;
   logic                   byte_first;
   logic                   sample_ready;
   logic                   clear_flags;
   logic [15:0]            gyro_x;
   logic [15:0]            gyro_y;
   logic [15:0]            gyro_z;
   logic                   sample_valid;
   logic [COUNT_WIDTH-1:0] sample_count;
   logic                   overrun;
   logic                   sync_error;

   modport master (
      output byte_data, byte_valid, byte_first,
      output sample_ready, clear_flags,
      input  gyro_x, gyro_y, gyro_z,
      input  sample_valid, sample_count,
      input  overrun, sync_error
   );

   modport slave (
      input  byte_data, byte_valid, byte_first,
      input  sample_ready, clear_flags,
      output gyro_x, gyro_y, gyro_z,
      output sample_valid, sample_count,
      output overrun, sync_error
   );
endinterface

// File: rtl/mpu6050_gyro_assembler.sv
// Assembles six-byte MPU6050 gyro bursts into X/Y/Z words
// behind a valid/ready output register with sticky error flags.
module mpu6050_gyro_assembler #(
   parameter bit BYTE_SWAP   = 1'b0,
   parameter int COUNT_WIDTH = 16
) (
   input logic                      clock,
   input logic                      reset_n,
   mpu6050_gyro_assembler_if.slave  bus
);
   localparam logic [0:0] WAIT_FIRST = 1'b0;
   localparam logic [0:0] COLLECT    = 1'b1;

   logic [0:0]             state_q, state_d;
   logic [2:0]             idx_q, idx_d;
   logic [7:0]             byte_q [6];
   logic [7:0]             byte_d [6];
   logic                   done_q, done_d;
   logic                   valid_q, valid_d;
   logic [15:0]            x_q, x_d, y_q, y_d, z_q, z_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic                   ovr_q, ovr_d;
   logic                   sync_q, sync_d;
   logic                   sync_set, ovr_set;
   logic                   consume, load;

   function automatic logic [15:0] word(input logic [7:0] a,
                                        input logic [7:0] b);
      return BYTE_SWAP ? {b, a} : {a, b};
   endfunction

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      byte_d   = byte_q;
      done_d   = 1'b0;
      sync_set = 1'b0;
      if (bus.byte_valid) begin
         if (bus.byte_first) begin
            sync_set  = (state_q == COLLECT);
            byte_d[0] = bus.byte_data;
            idx_d     = 3'd1;
            state_d   = COLLECT;
         end else if (state_q == COLLECT) begin
            byte_d[idx_q] = bus.byte_data;
            if (idx_q == 3'd5) begin
               done_d  = 1'b1;
               idx_d   = 3'd0;
               state_d = WAIT_FIRST;
            end else begin
               idx_d = idx_q + 3'd1;
            end
         end else begin
            sync_set = 1'b1;
         end
      end
   end

   // A finished burst is presented one edge after its last byte.
   always_comb begin
      consume = valid_q & bus.sample_ready;
      load    = done_q & (~valid_q | bus.sample_ready);
      ovr_set = done_q & valid_q & ~bus.sample_ready;
      valid_d = load | (valid_q & ~bus.sample_ready);
      count_d = count_q + COUNT_WIDTH'(consume);
      x_d     = load ? word(byte_q[0], byte_q[1]) : x_q;
      y_d     = load ? word(byte_q[2], byte_q[3]) : y_q;
      z_d     = load ? word(byte_q[4], byte_q[5]) : z_q;
      ovr_d   = ovr_set  | (ovr_q  & ~bus.clear_flags);
      sync_d  = sync_set | (sync_q & ~bus.clear_flags);
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= WAIT_FIRST;
         idx_q   <= 3'd0;
         byte_q  <= '{default: '0};
         done_q  <= 1'b0;
         valid_q <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         count_q <= '0;
         ovr_q   <= 1'b0;
         sync_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         byte_q  <= byte_d;
         done_q  <= done_d;
         valid_q <= valid_d;
         x_q     <= x_d;
         y_q     <= y_d;
         z_q     <= z_d;
         count_q <= count_d;
         ovr_q   <= ovr_d;
         sync_q  <= sync_d;
      end
   end

   assign bus.gyro_x       = x_q;
   assign bus.gyro_y       = y_q;
   assign bus.gyro_z       = z_q;
   assign bus.sample_valid = valid_q;
   assign bus.sample_count = count_q;
   assign bus.overrun      = ovr_q;
   assign bus.sync_error   = sync_q;
endmodule

// File: tb/tb_mpu6050_gyro_assembler.sv
// Self-checking bench: vector table, directed corner sequences,
// and random traffic against a queue-based burst model.
module tb_mpu6050_gyro_assembler;
   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   failures = 0;

   mpu6050_gyro_assembler_if #(.COUNT_WIDTH(16)) bus ();

   mpu6050_gyro_assembler #(
      .BYTE_SWAP(1'b0),
      .COUNT_WIDTH(16)
   ) dut (
      .clock(clk),
      .reset_n(rst_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        r, v, f;
      logic [7:0]  d;
      logic        rdy, clr;
      logic        ev;
      logic [15:0] ex, ey, ez, ecnt;
      logic        eov, esync;
   } vec_t;

   vec_t tbl [12];

   task automatic chk(input string n, input logic [31:0] a,
                      input logic [31:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
   endtask

   task automatic cyc(input logic r, input logic v, input logic f,
                      input logic [7:0] d, input logic rdy,
                      input logic clr);
      rst_n            = r;
      bus.byte_valid   = v;
      bus.byte_first   = f;
      bus.byte_data    = d;
      bus.sample_ready = rdy;
      bus.clear_flags  = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic burst(input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input logic [7:0] b3,
                        input logic [7:0] b4, input logic [7:0] b5,
                        input logic rdy);
      cyc(1, 1, 1, b0, rdy, 0);
      cyc(1, 1, 0, b1, rdy, 0);
      cyc(1, 1, 0, b2, rdy, 0);
      cyc(1, 1, 0, b3, rdy, 0);
      cyc(1, 1, 0, b4, rdy, 0);
      cyc(1, 1, 0, b5, rdy, 0);
   endtask

   // Reference model: a burst is a queue of bytes opened by a first flag
   logic [7:0]  mq [$];
   logic        m_pend;
   logic [15:0] m_pw [3];
   logic        m_valid, m_ov, m_sync;
   logic [15:0] m_x, m_y, m_z, m_cnt;

   task automatic model_step(input logic r, input logic v,
                             input logic f, input logic [7:0] d,
                             input logic rdy, input logic clr);
      logic ov_set, sy_set, was_valid;
      if (!r) begin
         mq.delete();
         m_pend = 0; m_valid = 0; m_ov = 0; m_sync = 0;
         m_x = 0; m_y = 0; m_z = 0; m_cnt = 0;
         return;
      end
      ov_set = 0;
      sy_set = 0;
      was_valid = m_valid;
      if (was_valid && rdy) m_cnt = m_cnt + 16'd1;
      m_valid = was_valid && !rdy;
      if (m_pend) begin
         if (!was_valid || rdy) begin
            m_x = m_pw[0]; m_y = m_pw[1]; m_z = m_pw[2];
            m_valid = 1;
         end else begin
            ov_set = 1;
         end
      end
      m_pend = 0;
      if (v) begin
         if (f) begin
            if (mq.size() != 0) sy_set = 1;
            mq.delete();
            mq.push_back(d);
         end else if (mq.size() == 0) begin
            sy_set = 1;
         end else begin
            mq.push_back(d);
            if (mq.size() == 6) begin
               for (int k = 0; k < 3; k++)
                  m_pw[k] = {mq[2*k], mq[2*k+1]};
               m_pend = 1;
               mq.delete();
            end
         end
      end
      m_ov   = ov_set | (m_ov & ~clr);
      m_sync = sy_set | (m_sync & ~clr);
   endtask

   initial begin
      rst_n = 0;
      bus.byte_valid = 0; bus.byte_first = 0; bus.byte_data = 0;
      bus.sample_ready = 0; bus.clear_flags = 0;

      // Basic burst, stray byte, flag clear
      tbl[0]  = '{0,0,0,8'h00,1,0, 0,16'h0,16'h0,16'h0,0,0,0};
      tbl[1]  = '{1,1,1,8'h01,1,0, 0,16'h0,16'h0,16'h0,0,0,0};
      tbl[2]  = '{1,1,0,8'h02,1,0, 0,16'h0,16'h0,16'h0,0,0,0};
      tbl[3]  = '{1,1,0,8'hFF,1,0, 0,16'h0,16'h0,16'h0,0,0,0};
      tbl[4]  = '{1,1,0,8'hFE,1,0, 0,16'h0,16'h0,16'h0,0,0,0};
      tbl[5]  = '{1,1,0,8'h80,1,0, 0,16'h0,16'h0,16'h0,0,0,0};
      tbl[6]  = '{1,1,0,8'h00,1,0, 0,16'h0,16'h0,16'h0,0,0,0};
      tbl[7]  = '{1,0,0,8'h00,1,0,
                  1,16'h0102,16'hFFFE,16'h8000,0,0,0};
      tbl[8]  = '{1,0,0,8'h00,1,0,
                  0,16'h0102,16'hFFFE,16'h8000,1,0,0};
      tbl[9]  = '{1,1,0,8'h55,1,0,
                  0,16'h0102,16'hFFFE,16'h8000,1,0,1};
      tbl[10] = '{1,0,0,8'h00,1,1,
                  0,16'h0102,16'hFFFE,16'h8000,1,0,0};
      tbl[11] = '{1,0,0,8'h00,1,0,
                  0,16'h0102,16'hFFFE,16'h8000,1,0,0};
      for (int i = 0; i < 12; i++) begin
         cyc(tbl[i].r, tbl[i].v, tbl[i].f, tbl[i].d,
             tbl[i].rdy, tbl[i].clr);
         chk($sformatf("vec%0d valid", i), bus.sample_valid, tbl[i].ev);
         chk($sformatf("vec%0d x", i), bus.gyro_x, tbl[i].ex);
         chk($sformatf("vec%0d y", i), bus.gyro_y, tbl[i].ey);
         chk($sformatf("vec%0d z", i), bus.gyro_z, tbl[i].ez);
         chk($sformatf("vec%0d cnt", i), bus.sample_count, tbl[i].ecnt);
         chk($sformatf("vec%0d ovr", i), bus.overrun, tbl[i].eov);
         chk($sformatf("vec%0d sync", i), bus.sync_error, tbl[i].esync);
      end

      // Overrun while output is held
      cyc(0, 0, 0, 0, 0, 0);
      burst(8'h11, 8'h11, 8'h11, 8'h11, 8'h11, 8'h11, 0);
      cyc(1, 0, 0, 0, 0, 0);
      chk("ovr first valid", bus.sample_valid, 1);
      burst(8'h22, 8'h22, 8'h22, 8'h22, 8'h22, 8'h22, 0);
      cyc(1, 0, 0, 0, 0, 0);
      chk("ovr set", bus.overrun, 1);
      chk("ovr held x", bus.gyro_x, 16'h1111);
      chk("ovr held z", bus.gyro_z, 16'h1111);
      cyc(1, 0, 0, 0, 0, 1);
      chk("ovr cleared", bus.overrun, 0);
      cyc(1, 0, 0, 0, 1, 0);
      chk("ovr count", bus.sample_count, 1);
      chk("ovr valid drop", bus.sample_valid, 0);

      // Broken burst resynchronises on the new first byte
      cyc(0, 0, 0, 0, 1, 0);
      cyc(1, 1, 1, 8'h01, 1, 0);
      cyc(1, 1, 0, 8'h02, 1, 0);
      cyc(1, 1, 0, 8'h03, 1, 0);
      burst(8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 0);
      cyc(1, 0, 0, 0, 0, 0);
      chk("resync sync", bus.sync_error, 1);
      chk("resync x", bus.gyro_x, 16'hAABB);
      chk("resync y", bus.gyro_y, 16'hCCDD);
      chk("resync z", bus.gyro_z, 16'hEEFF);

      // Load coincides with consumption of the held sample
      cyc(0, 0, 0, 0, 0, 0);
      burst(8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 0);
      cyc(1, 0, 0, 0, 0, 0);
      burst(8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 0);
      cyc(1, 0, 0, 0, 1, 0);
      chk("swap valid", bus.sample_valid, 1);
      chk("swap x", bus.gyro_x, 16'h2021);
      chk("swap ovr", bus.overrun, 0);
      chk("swap cnt", bus.sample_count, 1);

      // Reset mid-burst discards the partial bytes
      cyc(0, 0, 0, 0, 1, 0);
      cyc(1, 1, 1, 8'h33, 1, 0);
      cyc(1, 1, 0, 8'h34, 1, 0);
      cyc(1, 1, 0, 8'h35, 1, 0);
      cyc(1, 1, 0, 8'h36, 1, 0);
      cyc(0, 1, 0, 8'h37, 1, 0);
      chk("rst x", bus.gyro_x, 0);
      chk("rst valid", bus.sample_valid, 0);
      chk("rst sync", bus.sync_error, 0);
      burst(8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 1);
      chk("rst sync after", bus.sync_error, 0);
      cyc(1, 0, 0, 0, 1, 0);
      chk("rst new x", bus.gyro_x, 16'h4041);
      chk("rst new valid", bus.sample_valid, 1);
      cyc(1, 0, 0, 0, 1, 0);
      chk("rst cnt", bus.sample_count, 1);

      // Random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         logic r, v, f, rdy, clr;
         logic [7:0] d;
         r   = (i == 0) ? 1'b0 : ($urandom_range(0, 99) != 0);
         v   = $urandom_range(0, 3) != 0;
         f   = $urandom_range(0, 7) == 0;
         d   = 8'($urandom);
         rdy = $urandom_range(0, 2) == 0;
         clr = $urandom_range(0, 15) == 0;
         cyc(r, v, f, d, rdy, clr);
         model_step(r, v, f, d, rdy, clr);
         chk("rnd valid", bus.sample_valid, m_valid);
         chk("rnd x", bus.gyro_x, m_x);
         chk("rnd y", bus.gyro_y, m_y);
         chk("rnd z", bus.gyro_z, m_z);
         chk("rnd cnt", bus.sample_count, m_cnt);
         chk("rnd ovr", bus.overrun, m_ov);
         chk("rnd sync", bus.sync_error, m_sync);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mpu6050_gyro_assembler.md
MPU6050_GYRO_ASSEMBLER -- requirements
Module: mpu6050_gyro_assembler

Interface
REQ-001 SHALL have parameter BYTE_SWAP, default 0, meaning 0 = MSB byte arrives first (MPU6050 order), 1 = LSB byte first.
REQ-002 SHALL have parameter COUNT_WIDTH, default 16, meaning width of the delivered-sample counter.
REQ-003 SHALL have port clock, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, meaning synchronous, active-low reset.
REQ-005 SHALL have port byte_data, input, 8, meaning the register byte read from the I2C master (miso_data).
REQ-006 SHALL have port byte_valid, input, 1, meaning a one-cycle strobe that byte_data is valid; there is no input backpressure.
REQ-007 SHALL have port byte_first, input, 1, meaning, when qualified by byte_valid, that the byte is register 0x43 (GYRO_XOUT_H), the start of a burst.
REQ-008 SHALL have port sample_ready, input, 1, meaning the downstream consumer accepts the sample.
REQ-009 SHALL have port clear_flags, input, 1, meaning clear the sticky error flags.
REQ-010 SHALL have ports gyro_x, gyro_y and gyro_z, output, 16 each, meaning signed two's-complement axis words.
REQ-011 SHALL have port sample_valid, output, 1, meaning gyro_x/y/z hold an unconsumed sample.
REQ-012 SHALL have port sample_count, output, COUNT_WIDTH, meaning the number of samples accepted downstream.
REQ-013 SHALL have port overrun, output, 1, meaning sticky: a completed sample was dropped.
REQ-014 SHALL have port sync_error, output, 1, meaning sticky: a burst was broken or a byte arrived out of frame.

Function
REQ-015 SHALL implement states WAIT_FIRST and COLLECT, with a byte index idx in 0..5.
REQ-016 In WAIT_FIRST: byte_valid with byte_first stores the byte as byte 0, sets idx=1 and moves to COLLECT.
REQ-017 In WAIT_FIRST: byte_valid without byte_first is discarded and sets sync_error.
REQ-018 In COLLECT: byte_valid without byte_first stores the byte at idx and increments idx.
REQ-019 In COLLECT: byte_valid with byte_first discards the partial burst, sets sync_error, stores the byte as the new byte 0 and sets idx=1.
REQ-020 Byte order SHALL be X_H, X_L, Y_H, Y_L, Z_H, Z_L.
REQ-021 Each word SHALL be {H,L} when BYTE_SWAP=0 and {L,H} when BYTE_SWAP=1.
REQ-022 Storing byte idx=5 SHALL complete the burst and return the block to WAIT_FIRST.
REQ-023 Output latency SHALL be: burst completing on edge N gives gyro_x/y/z updated and sample_valid=1 visible after edge N+1 (one register stage).
REQ-024 Handshake: a sample is consumed on a cycle with sample_valid && sample_ready.
REQ-025 Handshake: on consumption, sample_count increments, wrapping modulo 2^COUNT_WIDTH.
REQ-026 Handshake: on consumption, sample_valid drops unless a new sample loads on the same edge.
REQ-027 Handshake: gyro_x/y/z SHALL remain stable while sample_valid=1 and sample_ready=0.
REQ-028 A sample completing while sample_valid=1 and sample_ready=0 SHALL be dropped, set overrun, and leave the output unchanged.
REQ-029 A sample completing on the same cycle as a consumption SHALL load, keep sample_valid=1, and not set overrun.
REQ-030 clear_flags SHALL clear overrun and sync_error on the next edge.
REQ-031 If a set event and clear_flags coincide, the set SHALL win.
REQ-032 byte_valid=0 SHALL hold all collection state; there is no timeout.

Reset
REQ-033 reset_n=0 sampled on a rising edge SHALL force state=WAIT_FIRST and idx=0.
REQ-034 The same reset SHALL force gyro_x/y/z=0, sample_valid=0, sample_count=0, overrun=0 and sync_error=0.
REQ-035 Reset mid-burst or with a pending sample SHALL discard the partial burst and the pending sample.
REQ-036 Inputs SHALL be ignored while reset_n=0.

Verification
REQ-037 Burst 0x01,0x02,0xFF,0xFE,0x80,0x00 (first flag on 0x01), ready=1 -> gyro_x=0x0102, gyro_y=0xFFFE (-2), gyro_z=0x8000, sample_valid=1 for one cycle, sample_count=1, no flags.
REQ-038 ready=0, two complete bursts (0x1111.. then 0x2222..) -> output keeps first burst values, overrun=1; clear_flags then ready=1 -> overrun=0, sample_count=1.
REQ-039 Three bytes, then byte_first with 0xAA followed by five more bytes -> sync_error=1, gyro_x=0xAA followed by the second burst's X_L; earlier bytes are absent.
REQ-040 Stray byte_valid without byte_first after reset -> sync_error=1, no sample produced, state stays WAIT_FIRST.
REQ-041 Sixth byte arriving on the same cycle that ready consumes the held sample -> new sample loaded, sample_valid stays 1, overrun=0.
REQ-042 reset_n=0 for one cycle after byte 4 of a burst, then a full burst -> all outputs 0 during reset; only the new burst is delivered, sample_count=1.
